uart_apb_master: RTL

UART_APB_MASTER -- requirements
Module: uart_apb_master

---
 rtl/uart_apb_master.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/uart_apb_master.sv
// Command/response front end that turns single accepted commands into APB transfers.
// One transfer is in flight at a time, and every output comes straight from a register.
module uart_apb_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_error,
    output logic                  rsp_timeout,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic                  PREADY,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PSLVERR
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    localparam logic [16:0] TIMEOUT_LIMIT = 17'(TIMEOUT);

    state_t                state, state_nxt;
    logic [15:0]           count, count_nxt;
    logic [16:0]           count_inc;
    logic                  cmd_ready_nxt, rsp_valid_nxt, rsp_error_nxt, rsp_timeout_nxt;
    logic                  psel_nxt, penable_nxt, pwrite_nxt;
    logic [DATA_WIDTH-1:0] rsp_rdata_nxt, pwdata_nxt;
    logic [ADDR_WIDTH-1:0] paddr_nxt;

    // The count plus one is the number of ACCESS edges including the current one.
    assign count_inc = {1'b0, count} + 17'd1;

    always_comb begin
        state_nxt       = state;
        count_nxt       = count;
        cmd_ready_nxt   = cmd_ready;
        rsp_valid_nxt   = rsp_valid;
        rsp_error_nxt   = rsp_error;
        rsp_timeout_nxt = rsp_timeout;
        rsp_rdata_nxt   = rsp_rdata;
        psel_nxt        = PSEL;
        penable_nxt     = PENABLE;
        pwrite_nxt      = PWRITE;
        paddr_nxt       = PADDR;
        pwdata_nxt      = PWDATA;
        case (state)
            IDLE: begin
                cmd_ready_nxt = 1'b1;
                if (cmd_valid && cmd_ready) begin
                    state_nxt     = SETUP;
                    cmd_ready_nxt = 1'b0;
                    count_nxt     = '0;
                    psel_nxt      = 1'b1;
                    penable_nxt   = 1'b0;
                    pwrite_nxt    = cmd_write;
                    paddr_nxt     = cmd_addr;
                    pwdata_nxt    = cmd_write ? cmd_wdata : '0;
                end
            end
            SETUP: begin
                state_nxt   = ACCESS;
                penable_nxt = 1'b1;
            end
            ACCESS: begin
                if (PREADY) begin
                    state_nxt       = RESP;
                    psel_nxt        = 1'b0;
                    penable_nxt     = 1'b0;
                    rsp_valid_nxt   = 1'b1;
                    rsp_error_nxt   = PSLVERR;
                    rsp_timeout_nxt = 1'b0;
                    rsp_rdata_nxt   = (!PWRITE && !PSLVERR) ? PRDATA : '0;
                end else if (TIMEOUT != 0 && count_inc >= TIMEOUT_LIMIT) begin
                    state_nxt       = RESP;
                    psel_nxt        = 1'b0;
                    penable_nxt     = 1'b0;
                    rsp_valid_nxt   = 1'b1;
                    rsp_error_nxt   = 1'b1;
                    rsp_timeout_nxt = 1'b1;
                    rsp_rdata_nxt   = '0;
                end else begin
                    count_nxt = count + 16'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt     = IDLE;
                    rsp_valid_nxt = 1'b0;
                    cmd_ready_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt     = IDLE;
                cmd_ready_nxt = 1'b0;
                rsp_valid_nxt = 1'b0;
                psel_nxt      = 1'b0;
                penable_nxt   = 1'b0;
            end
        endcase
    end

    // Reset drops any transfer in flight without producing a response.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state       <= IDLE;
            count       <= '0;
            cmd_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_error   <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= '0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
        end else begin
            state       <= state_nxt;
            count       <= count_nxt;
            cmd_ready   <= cmd_ready_nxt;
            rsp_valid   <= rsp_valid_nxt;
            rsp_error   <= rsp_error_nxt;
            rsp_timeout <= rsp_timeout_nxt;
            rsp_rdata   <= rsp_rdata_nxt;
            PSEL        <= psel_nxt;
            PENABLE     <= penable_nxt;
            PWRITE      <= pwrite_nxt;
            PADDR       <= paddr_nxt;
            PWDATA      <= pwdata_nxt;
        end
    end

endmodule
